// File: rtl/cxr_bank_ctrl.sv
// cxr_bank_ctrl: per-bank OBI front-end for cxr_ssm ComputeRAM macros.
// Each bank does its own address decode, keeps an in-order response pipeline
// matched to the macro read latency, and runs a power-gating sequencer.
//
// Power FSM (one per bank):
//   state    | meaning
//   ST_ON    | powered, accepting requests
//   ST_DRAIN | power-down requested, no new grants, waiting for pipeline empty
//   ST_GATE  | supply switched off, waiting PWR_DLY cycles to settle
//   ST_OFF   | fully powered down, ack_no low
//   ST_WAKE  | supply back on, waiting PWR_DLY cycles before granting

package cxr_bank_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic [2:0] {
    ST_ON    = 3'd0,
    ST_DRAIN = 3'd1,
    ST_GATE  = 3'd2,
    ST_OFF   = 3'd3,
    ST_WAKE  = 3'd4
  } pwr_state_e;
endpackage

module cxr_bank_ctrl
  import cxr_bank_pkg::*;
#(
  parameter int          NUM_BANKS  = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          BANK_WORDS = 4096,
  parameter int          ADDR_W     = 14,
  parameter int          READ_LAT   = 1,
  parameter int          PWR_DLY    = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  obi_req_t  [NUM_BANKS-1:0]          ram_req_i,
  output obi_resp_t [NUM_BANKS-1:0]          ram_resp_o,
  output logic      [NUM_BANKS-1:0]          err_o,
  input  logic      [NUM_BANKS-1:0]          pwrgate_ni,
  output logic      [NUM_BANKS-1:0]          pwrgate_ack_no,
  input  logic      [NUM_BANKS-1:0]          set_retentive_ni,
  output logic      [NUM_BANKS-1:0]          mem_cen_no,
  output logic      [NUM_BANKS-1:0]          mem_rdwen_o,
  output logic      [NUM_BANKS-1:0][ADDR_W-1:0] mem_a_o,
  output logic      [NUM_BANKS-1:0][31:0]    mem_d_o,
  output logic      [NUM_BANKS-1:0][31:0]    mem_bw_o,
  input  logic      [NUM_BANKS-1:0][31:0]    mem_q_i,
  input  logic      [NUM_BANKS-1:0]          mem_irq_i,
  output logic      [NUM_BANKS-1:0]          mem_pwr_off_o,
  output logic      [NUM_BANKS-1:0]          mem_ret_no,
  output logic      [NUM_BANKS-1:0]          irq_o,
  input  logic      [NUM_BANKS-1:0]          irq_clr_i
);

  localparam int          CNT_W      = $clog2(PWR_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PWR_DLY - 1);
  localparam logic [31:0] BANK_BYTES = 32'(BANK_WORDS) << 2;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    localparam logic [31:0] BANK_BASE = BASE_ADDR + BANK_BYTES * 32'(gi);

    pwr_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [READ_LAT-1:0]  vld_q, vld_d, we_q, we_d, err_q, err_d;
    logic                 irq_q, irq_d;
    logic                 ret_q;
    logic [31:0]          off;
    logic                 in_range, gnt, pipe_empty, rd_hit;
    obi_resp_t            resp;

    // Offset wraps in 32 bits, so addresses below the bank base land out of range.
    assign off        = ram_req_i[gi].addr - BANK_BASE;
    assign in_range   = off < BANK_BYTES;
    assign gnt        = ram_req_i[gi].req & (state_q == ST_ON) & pwrgate_ni[gi];
    assign pipe_empty = ~|vld_q;

    // Macro drive: only a granted in-range access touches the macro.
    always_comb begin
      mem_cen_no[gi]  = 1'b1;
      mem_rdwen_o[gi] = 1'b0;
      mem_a_o[gi]     = '0;
      mem_d_o[gi]     = '0;
      mem_bw_o[gi]    = '0;
      if (gnt && in_range) begin
        mem_cen_no[gi]  = 1'b0;
        mem_rdwen_o[gi] = ~ram_req_i[gi].we;
        mem_a_o[gi]     = off[ADDR_W+1:2];
        mem_d_o[gi]     = ram_req_i[gi].wdata;
        mem_bw_o[gi]    = {{8{ram_req_i[gi].be[3]}}, {8{ram_req_i[gi].be[2]}},
                           {8{ram_req_i[gi].be[1]}}, {8{ram_req_i[gi].be[0]}}};
      end
    end

    // Response shift register: grant info enters stage 0, emerges at READ_LAT-1.
    always_comb begin
      vld_d    = vld_q;
      we_d     = we_q;
      err_d    = err_q;
      vld_d[0] = gnt;
      we_d[0]  = ram_req_i[gi].we;
      err_d[0] = ~in_range;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        we_d[k]  = we_q[k-1];
        err_d[k] = err_q[k-1];
      end
    end

    // Response pipeline registers, flushed by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q <= '0;
        we_q  <= '0;
        err_q <= '0;
      end else begin
        vld_q <= vld_d;
        we_q  <= we_d;
        err_q <= err_d;
      end
    end

    assign rd_hit = vld_q[READ_LAT-1] & ~we_q[READ_LAT-1] & ~err_q[READ_LAT-1];

    // Assemble the OBI response for this bank.
    always_comb begin
      resp        = '0;
      resp.gnt    = gnt;
      resp.rvalid = vld_q[READ_LAT-1];
      resp.rdata  = rd_hit ? mem_q_i[gi] : 32'h0;
    end

    assign ram_resp_o[gi] = resp;
    assign err_o[gi]      = vld_q[READ_LAT-1] & err_q[READ_LAT-1];

    // Power sequencer next-state; the settle counter reloads on entry to GATE/WAKE.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_ON: begin
          if (!pwrgate_ni[gi]) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pwrgate_ni[gi]) begin
            state_d = ST_ON;
          end else if (pipe_empty) begin
            state_d = ST_GATE;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_GATE: begin
          if (cnt_q == '0) state_d = ST_OFF;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_OFF: begin
          if (pwrgate_ni[gi]) begin
            state_d = ST_WAKE;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_WAKE: begin
          if (cnt_q == '0) state_d = ST_ON;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = ST_ON;
      endcase
    end

    // Power sequencer state and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_ON;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign mem_pwr_off_o[gi]  = (state_q == ST_GATE) | (state_q == ST_OFF);
    assign pwrgate_ack_no[gi] = ~((state_q == ST_OFF) | (state_q == ST_WAKE));

    // Sticky interrupt: a new set outranks a simultaneous clear.
    assign irq_d = mem_irq_i[gi] ? 1'b1 : (irq_clr_i[gi] ? 1'b0 : irq_q);

    // Interrupt and retention registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        irq_q <= 1'b0;
        ret_q <= 1'b1;
      end else begin
        irq_q <= irq_d;
        ret_q <= set_retentive_ni[gi];
      end
    end

    assign irq_o[gi]      = irq_q;
    assign mem_ret_no[gi] = ret_q;
  end

endmodule

// File: doc/cxr_bank_ctrl.md
# cxr_bank_ctrl

Parametrised OBI front-end for an array of ComputeRAM (cxr_ssm) macros, one OBI slave port per bank, sitting between the bus crossbar and the memory macros in the memory subsystem. It generalises bank count, bank size, base address and macro read latency. It adds three things per bank: a pipelined response path, out-of-range error reporting, and a power-gating sequencer with drain and acknowledge.

## Interface
Parameters:
- NUM_BANKS, 2, number of banks and OBI ports
- BASE_ADDR, 32'h8000_0000, byte address of bank 0 word 0
- BANK_WORDS, 4096, 32-bit words per bank (power of two)
- ADDR_W, 14, macro word-address width (2**ADDR_W >= BANK_WORDS)
- READ_LAT, 1, macro cycles from CEN-low edge to valid Q (1..4)
- PWR_DLY, 8, cycles of macro power settle on gate and on wake (>=1)

Ports:
- clk_i  in  1  single clock for all logic
- rst_i  in  1  asynchronous, active-high reset
- ram_req_i  in  obi_req_t[NUM_BANKS]  per-bank OBI request (req, we, be, addr, wdata)
- ram_resp_o  out  obi_resp_t[NUM_BANKS]  per-bank OBI response (gnt, rvalid, rdata)
- err_o  out  NUM_BANKS  per-bank error flag, qualified by rvalid
- pwrgate_ni  in  NUM_BANKS  low = power-down requested for bank
- pwrgate_ack_no  out  NUM_BANKS  low = bank fully powered down
- set_retentive_ni  in  NUM_BANKS  low = retention requested
- mem_cen_no  out  NUM_BANKS  macro chip enable, active low
- mem_rdwen_o  out  NUM_BANKS  1 = read, 0 = write
- mem_a_o  out  NUM_BANKS x ADDR_W  macro word address
- mem_d_o  out  NUM_BANKS x 32  write data
- mem_bw_o  out  NUM_BANKS x 32  bit write enable
- mem_q_i  in  NUM_BANKS x 32  macro read data
- mem_irq_i  in  NUM_BANKS  macro interrupt, level
- mem_pwr_off_o  out  NUM_BANKS  1 = macro supply off
- mem_ret_no  out  NUM_BANKS  registered copy of set_retentive_ni
- irq_o  out  NUM_BANKS  sticky interrupt
- irq_clr_i  in  NUM_BANKS  clears irq_o

## Operation
- Offset for bank i: off = addr - BASE_ADDR - i*BANK_WORDS*4, computed in 32-bit unsigned arithmetic (wraps). Word address = off>>2, truncated to ADDR_W.
- In range when off < BANK_WORDS*4. Otherwise the access is out of range.
- gnt = req & (state == ON). There is no other backpressure; one access can be accepted per cycle.
- Granted in-range access: mem_cen_no=0 in the grant cycle. mem_rdwen_o=!we. mem_d_o=wdata. mem_bw_o[b]=be[b/8].
- Granted out-of-range access: macro untouched (mem_cen_no=1). Its response carries err_o=1 and rdata=0.
- Every granted access (read or write) produces exactly one rvalid, in order. Writes return rdata=0, err_o=0.
- Response pipeline per bank: a READ_LAT-deep shift register of {valid, we, err}. rdata=mem_q_i only for in-range reads, otherwise 0.
- Power FSM per bank:
  - ON -> DRAIN when pwrgate_ni=0. gnt is forced to 0 from that cycle.
  - DRAIN -> ON if pwrgate_ni returns to 1.
  - DRAIN -> GATE when the response pipeline is empty.
  - GATE: mem_pwr_off_o=1, count PWR_DLY cycles -> OFF. GATE is not abortable.
  - OFF: pwrgate_ack_no=0. OFF -> WAKE when pwrgate_ni=1.
  - WAKE: mem_pwr_off_o=0, pwrgate_ack_no stays 0, count PWR_DLY cycles -> ON (ack back to 1).
- Counter width is $clog2(PWR_DLY+1). The counter reloads on entering GATE and on entering WAKE.
- mem_ret_no is a register: the previous cycle's set_retentive_ni.
- irq_o sets on mem_irq_i=1 and holds. irq_clr_i clears it. If set and clear happen in the same cycle, set wins.

## Timing
- Reset values: state ON, gnt follows req, rvalid=0, err_o=0, rdata=0, pwrgate_ack_no=1, mem_pwr_off_o=0, mem_ret_no=1, irq_o=0, pipeline empty.
- mem_cen_no, mem_rdwen_o, mem_a_o, mem_d_o and mem_bw_o are combinational from the request when gnt=1.
- When gnt=0: mem_cen_no=1, and the other macro outputs are 0.
- rvalid, err_o and rdata are asserted exactly READ_LAT cycles after the grant cycle, for one cycle each, back-to-back for consecutive grants.
- Gate latency, from pwrgate_ni falling with an empty pipeline: DRAIN for 1 cycle, then GATE for PWR_DLY cycles, then ack_no low. Total PWR_DLY+1 cycles after the cycle in which pwrgate_ni was sampled low.
- Wake latency: WAKE for PWR_DLY cycles after pwrgate_ni is sampled high in OFF; gnt possible in the following cycle.
- Reset asserted mid-operation: the pipeline is flushed, so in-flight responses are lost without rvalid. The FSM returns to ON with mem_pwr_off_o=0 immediately (async).
- Banks are fully independent. Simultaneous events on different banks do not interact.

## Test plan
- READ_LAT=2, bank 0: write 0xDEADBEEF to 0x8000_0010 with be=4'b0011, then read the same address -> mem_bw_o=0x0000FFFF with mem_a_o=4; rvalid for the write 2 cycles after its grant; read rvalid 2 cycles after its grant returning mem_q_i.
- Bank 1: read 0x8000_4000 -> mem_a_o=0. Read 0x8000_3FFC on bank 1 -> no CEN; err_o=1 and rdata=0 with rvalid after READ_LAT.
- 4 back-to-back reads on bank 0 with READ_LAT=3 -> 4 consecutive gnt and 4 consecutive rvalid starting 3 cycles after the first gnt, in order.
- Drop pwrgate_ni[0] with 2 reads in flight -> gnt=0 immediately; both rvalids delivered; mem_pwr_off_o=1 after drain; ack_no=0 PWR_DLY=8 cycles later. Bank 1 keeps serving throughout.
- Drop pwrgate_ni then raise it during DRAIN -> returns to ON, and neither mem_pwr_off_o nor ack ever toggles.
- Raise pwrgate_ni from OFF -> mem_pwr_off_o=0 at once; ack_no=1 and gnt resumes after 8 cycles. Pulse mem_irq_i with irq_clr_i in the same cycle -> irq_o=1; clearing the next cycle -> irq_o=0.
